// File: rtl/ioff_chain_pkg.sv
// +----------------------------------------------------------------------+
// | ioff_chain_pkg : shared types and sizing helpers for the IO-flop scan |
// | chain controller.                                    Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

package ioff_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic int nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ioff_chain_shreg.sv
// +----------------------------------------------------------------------+
// | ioff_chain_shreg : chain image buffer with word write, serial bit     |
// | select/capture and pad-masked word read.             Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module ioff_chain_shreg
  import ioff_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8,
  localparam int NWORDS   = nwords(CHAIN_LEN, WORD_W),
  localparam int BIT_W    = cnt_w(CHAIN_LEN),
  localparam int WRD_W    = cnt_w(NWORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [WRD_W-1:0]  i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_cap_en,
  input  logic [BIT_W-1:0]  i_cap_idx,
  input  logic              i_cap_bit,
  input  logic [BIT_W-1:0]  i_sel_idx,
  output logic              o_sel_bit,
  input  logic [WRD_W-1:0]  i_rd_idx,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [CHAIN_LEN-1:0] r_buf;
  logic [CHAIN_LEN-1:0] w_buf_nxt;

  // The selected bit looks at the post-edge buffer so a word written on the
  // same edge that enters SHIFT is already visible to the first SI bit.
  always_comb begin
    w_buf_nxt = r_buf;
    for (int b = 0; b < CHAIN_LEN; b++) begin
      if (i_wr_en && ((b / WORD_W) == int'(i_wr_idx))) begin
        w_buf_nxt[b] = i_wr_data[b % WORD_W];
      end
    end
    if (i_cap_en) begin
      w_buf_nxt[i_cap_idx] = i_cap_bit;
    end
    o_sel_bit = w_buf_nxt[i_sel_idx];
  end

  always_comb begin
    o_rd_data = '0;
    for (int j = 0; j < WORD_W; j++) begin
      if ((int'(i_rd_idx) * WORD_W + j) < CHAIN_LEN) begin
        o_rd_data[j] = r_buf[int'(i_rd_idx) * WORD_W + j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else begin
      r_buf <= w_buf_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ioff_chain_ctrl.sv
// +----------------------------------------------------------------------+
// | ioff_chain_ctrl : loads/reads back the IO-flop scan chain through a   |
// | buffered valid/ready word interface.                 Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module ioff_chain_ctrl
  import ioff_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              CK,
  input  logic              global_reset,
  input  logic              op_start,
  input  logic              op_write,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic              chain_se,
  output logic              chain_si,
  input  logic              chain_so,
  output logic              chain_mode_sel
);

  localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
  localparam int BIT_W  = cnt_w(CHAIN_LEN);
  localparam int WRD_W  = cnt_w(NWORDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_write;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [WRD_W-1:0]  r_word;
  logic              r_img_valid;
  logic              w_img_nxt;
  logic              r_se;
  logic              r_si;
  logic              r_mode;
  logic              r_done;
  logic              w_cfg_hs;
  logic              w_rb_hs;
  logic              w_last_word;
  logic              w_last_bit;
  logic              w_sel_bit;

  assign w_cfg_hs    = (r_state == ST_FILL) && cfg_valid;
  assign w_rb_hs     = (r_state == ST_DRAIN) && rb_ready;
  assign w_last_word = (r_word == WRD_W'(NWORDS - 1));
  assign w_last_bit  = (r_bit == BIT_W'(CHAIN_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (op_start) w_state_nxt = op_write ? ST_FILL : ST_SHIFT;
      ST_FILL:  if (w_cfg_hs && w_last_word) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_rb_hs && w_last_word) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bit_nxt = r_bit;
    if (r_state == ST_SHIFT) begin
      w_bit_nxt = w_last_bit ? '0 : r_bit + BIT_W'(1);
    end
  end

  assign w_img_nxt = r_img_valid | ((r_state == ST_SHIFT) && w_last_bit && r_write);

  always_ff @(posedge CK) begin
    if (global_reset) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_bit       <= '0;
      r_word      <= '0;
      r_img_valid <= 1'b0;
      r_se        <= 1'b0;
      r_si        <= 1'b0;
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit       <= w_bit_nxt;
      r_img_valid <= w_img_nxt;
      if ((r_state == ST_IDLE) && op_start) begin
        r_write <= op_write;
      end
      if (w_cfg_hs || w_rb_hs) begin
        r_word <= w_last_word ? '0 : r_word + WRD_W'(1);
      end
      // SE must stay high for every shift cycle; MODE_SEL is released meanwhile.
      r_se   <= (w_state_nxt == ST_SHIFT);
      r_si   <= (w_state_nxt == ST_SHIFT) ? w_sel_bit : 1'b0;
      r_mode <= (w_state_nxt == ST_SHIFT) ? 1'b0 : w_img_nxt;
      r_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
    end
  end

  ioff_chain_shreg #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_shreg (
    .clk       (CK),
    .rst       (global_reset),
    .i_wr_en   (w_cfg_hs),
    .i_wr_idx  (r_word),
    .i_wr_data (cfg_data),
    .i_cap_en  (r_state == ST_SHIFT),
    .i_cap_idx (r_bit),
    .i_cap_bit (chain_so),
    .i_sel_idx (w_bit_nxt),
    .o_sel_bit (w_sel_bit),
    .i_rd_idx  (r_word),
    .o_rd_data (rb_data)
  );

  assign cfg_ready      = (r_state == ST_FILL);
  assign rb_valid       = (r_state == ST_DRAIN);
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign chain_se       = r_se;
  // Readback recirculates SO straight back into SI so the chain is restored.
  assign chain_si       = ((r_state == ST_SHIFT) && !r_write) ? chain_so : r_si;
  assign chain_mode_sel = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_ioff_chain_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_ioff_chain_ctrl : randomized bench with a behavioural 20-flop      |
// | chain and image-level reference model.               Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ioff_chain_ctrl;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = 3;
  localparam int TMO       = 200;

  logic              CK = 1'b0;
  logic              global_reset;
  logic              op_start;
  logic              op_write;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              rb_valid;
  logic              rb_ready;
  logic [WORD_W-1:0] rb_data;
  logic              busy;
  logic              done;
  logic              chain_se;
  logic              chain_si;
  logic              chain_so;
  logic              chain_mode_sel;

  logic                 model_clr;
  logic [CHAIN_LEN-1:0] chain_q;
  logic [CHAIN_LEN-1:0] exp_chain;
  logic                 exp_iv;
  bit                   noise_en;

  int n_tests  = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  int se_run   = 0;
  int se_last  = 0;
  int se_runs  = 0;
  int mode_bad = 0;

  always #5 CK = ~CK;

  ioff_chain_ctrl #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) dut (
    .CK             (CK),
    .global_reset   (global_reset),
    .op_start       (op_start),
    .op_write       (op_write),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_data       (cfg_data),
    .rb_valid       (rb_valid),
    .rb_ready       (rb_ready),
    .rb_data        (rb_data),
    .busy           (busy),
    .done           (done),
    .chain_se       (chain_se),
    .chain_si       (chain_si),
    .chain_so       (chain_so),
    .chain_mode_sel (chain_mode_sel)
  );

  // Scan chain: SI enters position 0, SO is position CHAIN_LEN-1; holds when SE=0.
  assign chain_so = chain_q[CHAIN_LEN-1];
  always @(posedge CK) begin
    if (model_clr) chain_q <= '0;
    else if (chain_se) chain_q <= {chain_q[CHAIN_LEN-2:0], chain_si};
  end

  always @(posedge CK) begin
    if (cfg_valid && cfg_ready) hs_cnt <= hs_cnt + 1;
  end

  always @(negedge CK) begin
    if (chain_se) se_run <= se_run + 1;
    else if (se_run != 0) begin
      se_last <= se_run;
      se_runs <= se_runs + 1;
      se_run  <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (chain_se && chain_mode_sel) mode_bad <= mode_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
    ncyc++;
    if (noise_en) begin
      op_start  = 1'($urandom % 2);
      op_write  = 1'($urandom % 2);
      cfg_valid = 1'($urandom % 2);
      cfg_data  = 8'($urandom);
    end else begin
      op_start  = 1'b0;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic run_op(input bit wr, input logic [23:0] img, input bit rnd);
    logic [23:0] exp_rb;
    logic [7:0]  hold;
    int hs0, dn0, run0, mb0, c0, k;
    bit hs;
    for (int b = 0; b < 24; b++) exp_rb[b] = (b < CHAIN_LEN) ? exp_chain[CHAIN_LEN-1-b] : 1'b0;
    hs0 = hs_cnt; dn0 = done_cnt; run0 = se_runs; mb0 = mode_bad; c0 = ncyc;
    op_start = 1'b1; op_write = wr; cfg_valid = 1'b0; rb_ready = 1'b1;
    noise_en = rnd;
    tick();
    chk("busy_after_start", busy, 1);
    if (wr) begin
      for (int n = 0; n < NWORDS; n++) begin
        hs = 0; k = 0;
        while (!hs && k < TMO) begin
          cfg_valid = rnd ? 1'($urandom % 2) : 1'b1;
          cfg_data  = cfg_valid ? img[n*8 +: 8] : 8'($urandom);
          hs = cfg_valid && cfg_ready;
          tick();
          k++;
        end
        chk("fill_handshake", hs, 1);
      end
    end
    for (int m = 0; m < NWORDS; m++) begin
      k = 0;
      while (!rb_valid && k < TMO) begin tick(); k++; end
      chk("rb_valid", rb_valid, 1);
      if (rnd && m == 1) begin
        rb_ready = 1'b0;
        hold = rb_data;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("rb_stall_stable", rb_data, hold);
        end
        chk("rb_valid_stall", rb_valid, 1);
        rb_ready = 1'b1;
      end
      chk($sformatf("rb_word%0d", m), rb_data, exp_rb[m*8 +: 8]);
      if (m == NWORDS - 1) noise_en = 0;
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    chk("rb_valid_idle", rb_valid, 0);
    if (!wr && !rnd) chk("rb_latency", ncyc - c0, 24);
    if (wr) begin
      for (int b = 0; b < CHAIN_LEN; b++) exp_chain[CHAIN_LEN-1-b] = img[b];
      exp_iv = 1'b1;
    end
    chk("mode_sel", chain_mode_sel, exp_iv);
    tick();
    chk("done_one_cycle", done, 0);
    chk("done_count", done_cnt - dn0, 1);
    chk("cfg_hs_count", hs_cnt - hs0, wr ? 3 : 0);
    chk("se_runs", se_runs - run0, 1);
    chk("se_run_len", se_last, CHAIN_LEN);
    chk("mode_in_shift", mode_bad - mb0, 0);
    chk("chain_image", chain_q, exp_chain);
  endtask

  task automatic reset_mid_shift(input logic [23:0] img);
    int dn0;
    dn0 = done_cnt;
    noise_en = 0;
    op_start = 1'b1; op_write = 1'b1;
    tick();
    for (int n = 0; n < NWORDS; n++) begin
      cfg_valid = 1'b1;
      cfg_data  = img[n*8 +: 8];
      tick();
    end
    chk("se_shift0", chain_se, 1);
    repeat (7) tick();
    chk("se_shift7", chain_se, 1);
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_se", chain_se, 0);
    chk("rst_mode", chain_mode_sel, 0);
    chk("rst_done", done, 0);
    tick();
    tick();
    chk("rst_no_done", done_cnt - dn0, 0);
    exp_chain = chain_q;
    exp_iv = 1'b0;
  endtask

  task automatic idle_noise();
    int hs0;
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'($urandom % 2);
      cfg_data  = 8'($urandom);
      chk("idle_cfg_ready", cfg_ready, 0);
      tick();
    end
    chk("idle_hs_count", hs_cnt - hs0, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    global_reset = 1'b1; model_clr = 1'b1;
    op_start = 1'b0; op_write = 1'b0; cfg_valid = 1'b0; cfg_data = '0; rb_ready = 1'b1;
    noise_en = 0; exp_chain = '0; exp_iv = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_cfg_ready0", cfg_ready, 0);
    chk("rst_rb_valid0", rb_valid, 0);
    chk("rst_se0", chain_se, 0);
    chk("rst_si0", chain_si, 0);
    chk("rst_mode0", chain_mode_sel, 0);
    chk("rst_rb_data0", rb_data, 0);
    global_reset = 1'b0; model_clr = 1'b0;
    tick();

    run_op(1'b1, 24'h0F3CA5, 1'b0);
    run_op(1'b0, 24'h000000, 1'b0);
    idle_noise();
    run_op(1'b1, 24'($urandom), 1'b1);
    run_op(1'b0, 24'h000000, 1'b1);
    reset_mid_shift(24'($urandom));
    run_op(1'b1, 24'($urandom), 1'b0);
    run_op(1'b0, 24'h000000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom % 2), 24'($urandom), 1'($urandom % 2));
      idle_noise();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
